// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared RV32I load/store funct3 codes, responder states and access-size helpers.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} respState_t;

    // 0 = byte, 1 = half, 2 = word; unused codes fall through to word
    function automatic logic [1:0] accessSize(input logic [2:0] funct3);
        return (funct3 == F3_W) ? 2'd2 :
               (funct3 == F3_B  || funct3 == F3_BU) ? 2'd0 :
               (funct3 == F3_H  || funct3 == F3_HU) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
        return (accessSize(funct3) == 2'd1) ? addrLo[0] :
               (accessSize(funct3) == 2'd2) ? |addrLo : 1'b0;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane placement for stores and
// lane extraction with sign/zero extension for loads.
module lsu_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] loadWord,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord,
    output logic [31:0] loadData
);

    logic [1:0]  size;
    logic        zeroExt;
    logic [31:0] shifted;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        size      = accessSize(funct3);
        zeroExt   = (funct3 == F3_BU) || (funct3 == F3_HU);
        shifted   = loadWord >> {addrLo, 3'b000};
        ldByte    = shifted[7:0];
        ldHalf    = addrLo[1] ? loadWord[31:16] : loadWord[15:0];
        byteEn    = (size == 2'd0) ? 4'b0001 << addrLo :
                    (size == 2'd1) ? (addrLo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // replicate narrow data into every lane; byteEn picks the live one
        storeWord = (size == 2'd0) ? {4{storeData[7:0]}} :
                    (size == 2'd1) ? {2{storeData[15:0]}} : storeData;
        loadData  = (size == 2'd0) ? {{24{~zeroExt & ldByte[7]}}, ldByte} :
                    (size == 2'd1) ? {{16{~zeroExt & ldHalf[15]}}, ldHalf} : loadWord;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage load/store target with fixed LATENCY and one-cycle response pulse.
// DMEM_MISALIGN_TRAP_EN: when defined, misaligned H/W requests answer at once with resp_err.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    respState_t state, stateNext;
    logic [3:0]  count;
    logic [ADDR_WIDTH+1:0] addrQ, accAddr;
    logic [31:0] wdataQ, accWdata;
    logic        writeQ, accWrite;
    logic [2:0]  funct3Q, accFunct3;
    logic        errQ;
    logic        accept, misaligned, doAccess;
    logic [3:0]  byteEn;
    logic [31:0] storeWord, loadData;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic        unusedAddrBits;

    logic [31:0] mem [2**ADDR_WIDTH];

    assign unusedAddrBits = ^req_addr[31:ADDR_WIDTH+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = isMisaligned(req_funct3, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept     = (state == IDLE) && req_valid;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = errQ;
    assign stall      = req_valid & ~resp_valid;

    // with LATENCY = 1 the access happens on the accepting edge, straight from the request
    always_comb begin
        accAddr   = (state == IDLE) ? req_addr[ADDR_WIDTH+1:0] : addrQ;
        accWdata  = (state == IDLE) ? req_wdata : wdataQ;
        accWrite  = (state == IDLE) ? req_write : writeQ;
        accFunct3 = (state == IDLE) ? req_funct3 : funct3Q;
        wordIdx   = accAddr[ADDR_WIDTH+1:2];
        doAccess  = (state == WAIT) ? (count == 4'd1) : (accept && !misaligned && LATENCY == 1);
        stateNext = (state == RESP) ? IDLE :
                    (state == WAIT) ? ((count == 4'd1) ? RESP : WAIT) :
                    accept ? ((misaligned || LATENCY == 1) ? RESP : WAIT) : IDLE;
    end

    lsu_lane_align align (
        .funct3    (accFunct3),
        .addrLo    (accAddr[1:0]),
        .storeData (accWdata),
        .loadWord  (mem[wordIdx]),
        .byteEn    (byteEn),
        .storeWord (storeWord),
        .loadData  (loadData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            resp_rdata <= 32'd0;
            errQ       <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                addrQ   <= req_addr[ADDR_WIDTH+1:0];
                wdataQ  <= req_wdata;
                writeQ  <= req_write;
                funct3Q <= req_funct3;
                count   <= 4'(LATENCY - 1);
                errQ    <= misaligned;
                if (misaligned)
                    resp_rdata <= 32'd0;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (doAccess)
                resp_rdata <= accWrite ? 32'd0 : loadData;
        end
    end

    // reset on the access edge cancels a pending store
    always_ff @(posedge clk) begin
        if (doAccess && accWrite && !reset)
            for (int b = 0; b < 4; b++)
                if (byteEn[b])
                    mem[wordIdx][8*b +: 8] <= storeWord[8*b +: 8];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, hand-built corner sequences and
// randomized traffic checked against a byte-array memory model.
module tb_dmem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int MEM_BYTES = 4 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    int errors = 0;
    int checks = 0;
    logic [7:0] mb [MEM_BYTES];

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    // reference: byte-addressed memory, size from funct3, wrap at MEM_BYTES
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        int base;
        logic [31:0] v;
        n = sizeOf(f3);
        rd = 32'd0;
        er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (int'(a % 32'(n)) != 0) begin
            er = 1'b1;
            return;
        end
`endif
        base = int'(a % 32'(MEM_BYTES)) / n * n;
        if (w) begin
            for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
            if (n == 1 && f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (n == 2 && f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endtask

    // call just after a posedge with the DUT idle; req_valid held until the response
    task automatic doReq(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er,
                         output int lat);
        bit got;
        req_valid = 1'b1;
        req_write = w;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = d;
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_stall", stall, 1);
        @(posedge clk);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1;
            else begin
                check("wait_stall", stall, 1);
                check("wait_ready", req_ready, 0);
            end
        end
        if (!got) check("resp_timeout", 0, 1);
        check("resp_stall", stall, 0);
        check("resp_ready", req_ready, 0);
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    logic [31:0] rd, erd, d, a;
    logic        er, eer, w;
    logic [2:0]  f3;
    int          lat;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_ready", req_ready, 1);
        check("rst_stall", stall, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        vecs.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h12, 32'hFFFF8001, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0});
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1});
`else
        vecs.push_back('{1'b0, 3'b010, 32'h11, 32'h0, 32'h8001BEEF, 1'b0});
`endif
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0});
        vecs.push_back('{1'b1, 3'b010, 32'h10 + (32'd4 << AW), 32'h0BADF00D, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h0BADF00D, 1'b0});
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back('{1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1});
`else
        vecs.push_back('{1'b0, 3'b001, 32'h13, 32'h0, 32'h00000BAD, 1'b0});
`endif

        foreach (vecs[i]) begin
            doReq(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].expData);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].expErr});
            check($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].expErr ? 32'd1 : 32'(LAT));
        end

        // request held continuously: acceptance only in IDLE, once per LAT+1 cycles
        req_valid = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        for (int k = 0; k < 3 * (LAT + 1); k++) begin
            @(negedge clk);
            check($sformatf("b2b_ready%0d", k), req_ready, (k % (LAT + 1)) == 0);
            check($sformatf("b2b_valid%0d", k), resp_valid, (k % (LAT + 1)) == LAT);
            check($sformatf("b2b_stall%0d", k), stall, (k % (LAT + 1)) != LAT);
            if (resp_valid) check($sformatf("b2b_rdata%0d", k), resp_rdata, 32'h0BADF00D);
            @(posedge clk);
        end
        #1 req_valid = 1'b0;

        // reset in the last WAIT cycle of a store drops it
        doReq(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, rd, er, lat);
        doReq(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        check("pre_rst_load", rd, 32'hCAFEF00D);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h20;
        req_wdata = 32'h11111111;
        @(posedge clk);
        repeat (LAT - 2) @(posedge clk);
        #1 reset = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", resp_valid, 0);
        check("midrst_rdata", resp_rdata, 0);
        check("midrst_err", resp_err, 0);
        check("midrst_ready", req_ready, 1);
        check("midrst_stall", stall, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            check("midrst_noresp", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        doReq(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        check("midrst_kept", rd, 32'hCAFEF00D);

        // randomized traffic over a preloaded 16-word window, with address aliasing
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model(1'b1, 3'b010, 32'h100 + 32'(4 * i), d, erd, eer);
            doReq(1'b1, 3'b010, 32'h100 + 32'(4 * i), d, rd, er, lat);
        end
        for (int k = 0; k < 300; k++) begin
            w = ($urandom % 3) == 0;
            f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a = 32'h100 + ($urandom % 64) + (($urandom % 4) << (AW + 2));
            d = $urandom;
            model(w, f3, a, d, erd, eer);
            doReq(w, f3, a, d, rd, er, lat);
            check($sformatf("rnd%0d_rdata w=%0b f3=%0d a=%h", k, w, f3, a), rd, erd);
            check($sformatf("rnd%0d_err", k), {31'd0, er}, {31'd0, eer});
            check($sformatf("rnd%0d_lat", k), 32'(lat), eer ? 32'd1 : 32'(LAT));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the memory-stage load/store request interface.
- Accepts one request at a time from the pipeline memory stage and services it against an internal word array with a configurable fixed latency.
- Returns sign/zero-extended load data with a one-cycle response pulse.
- Drives a stall line that holds the pipeline until the response arrives.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from acceptance to response pulse; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present (load or store)
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  raw rs2 value; responder performs lane placement
- req_ready  output  1  high only in IDLE
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  misaligned flag, valid with resp_valid
- stall  output  1  combinational: req_valid & ~resp_valid

Behaviour:
- Interface decided: one clock `clk`; synchronous active-high `reset`.
- Reset:
  - state = IDLE, counter = 0.
  - resp_valid, resp_rdata and resp_err = 0.
  - The memory array is not cleared.
  - Reset mid-operation drops the pending access; a pending store never commits.
- IDLE state:
  - req_ready = 1.
  - On req_valid, capture addr, wdata, write and funct3.
  - Misaligned request (H/HU with addr[0] = 1, W with addr[1:0] != 0): go to RESP with err = 1. No array access.
  - Otherwise: counter = LATENCY-1; go to WAIT, or go directly to RESP if LATENCY = 1.
- WAIT state:
  - Decrement the counter each cycle.
  - When the counter reaches 0, perform the access on that edge and go to RESP:
    - Store: update the selected bytes only.
    - Load: register the extracted data.
- RESP state:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready = 0; a request held during RESP is not re-accepted. The pipeline advances because stall drops.
- Latency: request accepted on the edge closing cycle T, resp_valid high during cycle T+LATENCY. Throughput is one request per LATENCY+1 cycles.
- Address mapping: word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so accesses wrap.
- Store lanes:
  - SB writes wdata[7:0] to byte addr[1:0].
  - SH writes wdata[15:0] to half addr[1].
  - SW writes the full word.
- Load extraction:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - Unused funct3 codes (011, 110, 111) behave as W.
- resp_rdata holds its value until the next response. It is forced to 0 on store responses and on error responses.
- Simultaneous events:
  - reset wins over everything.
  - req_valid in WAIT is ignored; it is not queued.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned requests are rejected as described above, with resp_err = 1.
- Undefined:
  - Low address bits are masked: H uses addr[1] only; W ignores addr[1:0].
  - The access proceeds normally through WAIT.
  - resp_err is tied to 0.

Decomposition:
- Package rv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The responder state encoding IDLE/WAIT/RESP.
- Sub-module lsu_lane_align, combinational:
  - Store side: byte-enable plus shifted write data.
  - Load side: lane extraction plus sign/zero extension.
  - Reused later by the instruction-fetch side if needed.

Test Plan:
- Reset mid-op: SW 0x11111111 to 0x20, then assert reset on the cycle before RESP -> no response; LW 0x20 afterwards returns the prior contents; all outputs 0 during reset.
- Word round trip: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each resp_valid exactly 2 cycles after acceptance (LATENCY = 2); rdata 0xDEADBEEF; stall high for 2 cycles per request.
- Byte/sign: SB 0x80 to addr 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- Half: SH 0x8001 to 0x12, then LH 0x12 -> 0xFFFF8001; LHU -> 0x00008001; byte 0x10 unchanged (0xEF).
- Misaligned (macro defined): LW 0x11 -> resp_valid on the next cycle with resp_err = 1, rdata 0, memory untouched. Macro undefined: the same request returns the word at 0x10 with err 0.
- Wrap and back-to-back: SW to 0x10 + (4 << ADDR_WIDTH) aliases 0x10. Consecutive requests with req_valid held show req_ready = 0 in WAIT/RESP and acceptance only in IDLE.
